// File: rtl/target_generator_pkg.sv
// Shared snake-game definitions: grid size, coordinate widths and the target FSM encoding.
package target_generator_pkg;
  localparam int GRID_H = 160;
  localparam int GRID_V = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    ARMED = 2'd2,
    HIT   = 2'd3
  } state_t;
endpackage

// File: rtl/target_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); seed must be non-zero.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] q
);
  always_ff @(posedge CLK) begin
    if (!RESET) q <= SEED;
    else        q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end
endmodule

// File: rtl/target_generator.sv
// Places the food target from LFSR candidates and emits a one-cycle REACHED_TARGET pulse on a head hit.
// All outputs registered; a rejected candidate simply retries with the next LFSR value.
module target_generator
  import target_generator_pkg::*;
#(
  parameter int          H_CELLS   = GRID_H,
  parameter int          V_CELLS   = GRID_V,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           GAME_ACTIVE,
  input  logic           HEAD_VALID,
  input  logic [X_W-1:0] HEAD_X,
  input  logic [Y_W-1:0] HEAD_Y,
  output logic           REACHED_TARGET,
  output logic [X_W-1:0] TARGET_X,
  output logic [Y_W-1:0] TARGET_Y,
  output logic           TARGET_VALID
);
  localparam logic [X_W:0]   X_LIM = (X_W+1)'(H_CELLS);
  localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(V_CELLS);
  localparam logic [X_W-1:0] X_MID = X_W'(H_CELLS / 2);
  localparam logic [Y_W-1:0] Y_MID = Y_W'(V_CELLS / 2);

  state_t         state;
  logic [15:0]    lfsr_q;
  logic           lfsr_unused;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_ok;
  logic           head_hit;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .q     (lfsr_q)
  );

  assign cand_x      = lfsr_q[7:0];
  assign cand_y      = lfsr_q[14:8];
  assign lfsr_unused = lfsr_q[15];

  // A candidate under the snake head would score instantly, so it is rejected too.
  assign cand_ok  = ({1'b0, cand_x} < X_LIM) && ({1'b0, cand_y} < Y_LIM) &&
                    !((cand_x == HEAD_X) && (cand_y == HEAD_Y));
  assign head_hit = HEAD_VALID && (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= IDLE;
      REACHED_TARGET <= 1'b0;
      TARGET_VALID   <= 1'b0;
      TARGET_X       <= X_MID;
      TARGET_Y       <= Y_MID;
    end else if (!GAME_ACTIVE) begin
      state          <= IDLE;
      REACHED_TARGET <= 1'b0;
      TARGET_VALID   <= 1'b0;
    end else begin
      REACHED_TARGET <= 1'b0;
      case (state)
        IDLE: state <= PLACE;
        PLACE: begin
          if (cand_ok) begin
            TARGET_X     <= cand_x;
            TARGET_Y     <= cand_y;
            TARGET_VALID <= 1'b1;
            state        <= ARMED;
          end
        end
        ARMED: begin
          if (head_hit) begin
            REACHED_TARGET <= 1'b1;
            TARGET_VALID   <= 1'b0;
            state          <= HIT;
          end
        end
        HIT: state <= PLACE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_target_generator.sv
// Scoreboard bench for target_generator: stimulus queues expected placements/pulses, a negedge monitor checks them.
module tb_target_generator;
  import target_generator_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       GAME_ACTIVE = 1'b0;
  logic       HEAD_VALID = 1'b0;
  logic [7:0] HEAD_X = 8'd80;
  logic [6:0] HEAD_Y = 7'd60;
  logic       REACHED_TARGET;
  logic [7:0] TARGET_X;
  logic [6:0] TARGET_Y;
  logic       TARGET_VALID;

  always #5 CLK = ~CLK;

  target_generator dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .GAME_ACTIVE    (GAME_ACTIVE),
    .HEAD_VALID     (HEAD_VALID),
    .HEAD_X         (HEAD_X),
    .HEAD_Y         (HEAD_Y),
    .REACHED_TARGET (REACHED_TARGET),
    .TARGET_X       (TARGET_X),
    .TARGET_Y       (TARGET_Y),
    .TARGET_VALID   (TARGET_VALID)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    int         due;
  } place_t;

  place_t      exp_q[$];
  int          pulse_q[$];
  int          total = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pulses = 0;
  logic [15:0] ref_lfsr = SEED;
  logic [3:0]  score = 4'd0;
  logic        score_clr = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_reached = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // First accepted candidate starting from LFSR value v; due = cycle the target shows valid.
  function automatic place_t predict(input logic [15:0] v, input logic [7:0] hx,
                                     input logic [6:0] hy, input int base);
    place_t      p;
    logic [15:0] s = v;
    int          k = 0;
    while (!(s[7:0] < 8'd160 && s[14:8] < 7'd120 && !(s[7:0] == hx && s[14:8] == hy)) && k < 2000) begin
      s = lfsr_next(s);
      k++;
    end
    p.x   = s[7:0];
    p.y   = s[14:8];
    p.due = base + k;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR and chained 4-bit score counter.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET) ref_lfsr <= SEED;
    else        ref_lfsr <= lfsr_next(ref_lfsr);
    if (!RESET || score_clr)  score <= 4'd0;
    else if (REACHED_TARGET)  score <= score + 4'd1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a placement or a pulse.
  always @(negedge CLK) begin
    place_t p;
    if (RESET) begin
      if (TARGET_VALID && !prev_valid) begin
        check("placement_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("place_x", TARGET_X, p.x);
          check("place_y", TARGET_Y, p.y);
          check("place_cycle", cyc, p.due);
        end
        check("x_in_range", TARGET_X < 8'd160, 1);
        check("y_in_range", TARGET_Y < 7'd120, 1);
      end
      if (REACHED_TARGET) begin
        pulses++;
        check("pulse_expected", pulse_q.size() > 0, 1);
        if (pulse_q.size() > 0) void'(pulse_q.pop_front());
        check("no_back_to_back", prev_reached, 0);
      end
    end
    prev_valid   = TARGET_VALID;
    prev_reached = REACHED_TARGET;
  end

  task automatic wait_valid();
    int n = 0;
    while (!TARGET_VALID && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!TARGET_VALID) check("valid_timeout", TARGET_VALID, 1);
  endtask

  task automatic start_game();
    @(negedge CLK);
    GAME_ACTIVE = 1'b1;
    HEAD_VALID  = 1'b0;
    exp_q.push_back(predict(lfsr_next(ref_lfsr), HEAD_X, HEAD_Y, cyc + 2));
    @(negedge CLK);
    wait_valid();
  endtask

  task automatic do_hit();
    @(negedge CLK);
    HEAD_X     = TARGET_X;
    HEAD_Y     = TARGET_Y;
    HEAD_VALID = 1'b1;
    pulse_q.push_back(1);
    exp_q.push_back(predict(lfsr_next(lfsr_next(ref_lfsr)), TARGET_X, TARGET_Y, cyc + 3));
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    check("hit_pulse_high", REACHED_TARGET, 1);
    check("hit_valid_drop", TARGET_VALID, 0);
    @(negedge CLK);
    check("hit_pulse_one_cycle", REACHED_TARGET, 0);
    wait_valid();
    check("new_target_not_head", (TARGET_X == HEAD_X) && (TARGET_Y == HEAD_Y), 0);
  endtask

  initial begin
    logic [7:0] sx;
    logic [6:0] sy;
    int         base;
    int         hits;
    int         hx;
    int         hy;
    logic       idle_ok;

    // Reset and idle
    repeat (3) @(negedge CLK);
    check("rst_tx", TARGET_X, 80);
    check("rst_ty", TARGET_Y, 60);
    check("rst_valid", TARGET_VALID, 0);
    check("rst_reached", REACHED_TARGET, 0);
    RESET   = 1'b1;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (TARGET_X != 8'd80 || TARGET_Y != 7'd60 || TARGET_VALID !== 1'b0 || REACHED_TARGET !== 1'b0)
        idle_ok = 1'b0;
    end
    check("idle_hold_20", idle_ok, 1);

    // Placement, then a hit with the chained score counter
    start_game();
    check("score_before_hit", score, 0);
    do_hit();
    check("score_after_hit", score, 1);

    // Near misses: adjacent cells must not score or move the target
    sx   = TARGET_X;
    sy   = TARGET_Y;
    base = pulses;
    @(negedge CLK);
    HEAD_X = sx + 8'd1; HEAD_Y = sy; HEAD_VALID = 1'b1;
    @(negedge CLK);
    HEAD_X = sx; HEAD_Y = sy - 7'd1;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check("miss_no_pulse", pulses - base, 0);
    check("miss_tx", TARGET_X, sx);
    check("miss_ty", TARGET_Y, sy);
    check("miss_valid", TARGET_VALID, 1);

    // Abort: matching head in the same cycle GAME_ACTIVE drops
    @(negedge CLK);
    HEAD_X = TARGET_X; HEAD_Y = TARGET_Y; HEAD_VALID = 1'b1; GAME_ACTIVE = 1'b0;
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    check("abort_no_pulse", REACHED_TARGET, 0);
    check("abort_valid", TARGET_VALID, 0);
    repeat (3) @(negedge CLK);
    check("abort_pulse_count", pulses - base, 0);
    check("abort_stays_idle", TARGET_VALID, 0);

    // Soak: random head walk with forced hits
    HEAD_X = 8'd0; HEAD_Y = 7'd0;
    start_game();
    @(negedge CLK);
    score_clr = 1'b1;
    @(negedge CLK);
    score_clr = 1'b0;
    base = pulses;
    hits = 0;
    hx   = 0;
    hy   = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 66 == 33 && hits < 15) begin
        do_hit();
        hits++;
        hx = HEAD_X;
        hy = HEAD_Y;
      end else begin
        hx = hx + $urandom_range(2) - 1;
        hy = hy + $urandom_range(2) - 1;
        if (hx < 0) hx = 159;
        if (hx > 159) hx = 0;
        if (hy < 0) hy = 119;
        if (hy > 119) hy = 0;
        if (hx == TARGET_X && hy == TARGET_Y) hx = hx ^ 1;
        @(negedge CLK);
        HEAD_X     = 8'(hx);
        HEAD_Y     = 7'(hy);
        HEAD_VALID = 1'b1;
      end
    end
    @(negedge CLK);
    HEAD_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check("soak_pulses", pulses - base, 15);
    check("soak_score", score, 15);
    check("soak_target_range", TARGET_X < 8'd160 && TARGET_Y < 7'd120, 1);
    check("placements_drained", exp_q.size(), 0);
    check("pulses_drained", pulse_q.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
